call_stack_param: RTL and testbench

- Parametrised return-address stack for the decode stage of the pipelined core.
- Generalises the fixed 12-bit call stack with configurable width, depth and full-stack policy.
- Adds occupancy reporting, same-cycle push+pop (tail call), flush, and sticky overflow/underflow flags.
- The controller's push/pop drive it; `top` feeds the PC input mux.

---
 rtl/call_stack_param.sv | 194 +++++++++++++++++++
 tb/tb_call_stack_param.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/call_stack_param.sv
// call_stack_param: parametrised return-address stack for the decode stage.
//
// A LIFO of DEPTH entries, each WIDTH bits wide. The controller drives
// push/pop/flush; the current top entry feeds the PC input mux with zero
// read latency. Supports a same-cycle push+pop (tail call: replace the top),
// flush, occupancy reporting, and sticky overflow/underflow flags.
//
// Full-stack policy is chosen by WRAP_MODE:
//   0 : a push into a full stack is dropped (overflow is flagged)
//   1 : the stack behaves as a ring; the push overwrites the oldest entry
//       (overflow is still flagged so software can tell history was lost)
//
// DEPTH need not be a power of two, so the slot pointer wraps explicitly
// instead of relying on binary roll-over.

module call_stack_param #(
    parameter int WIDTH     = 12,
    parameter int DEPTH     = 8,
    parameter int WRAP_MODE = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic                         err_clr,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             top,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full,
    output logic                         overflow,
    output logic                         underflow
);

    // Pointer width addresses DEPTH slots; count width must also hold DEPTH.
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    localparam logic [PW-1:0] SP_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    // What the stack does this cycle, after priority resolution.
    typedef enum logic [2:0] {
        OP_HOLD,            // nothing requested
        OP_FLUSH,           // discard every entry
        OP_PUSH,            // push with room available
        OP_PUSH_FULL,       // push while full: drop or overwrite oldest
        OP_POP,             // pop with at least one entry
        OP_POP_EMPTY,       // pop while empty: flag only
        OP_REPLACE,         // push+pop with entries: overwrite top in place
        OP_PUSH_POP_EMPTY   // push+pop while empty: acts as push, flags underflow
    } op_e;

    // Storage and registered state.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    sp;
    logic [CW-1:0]    cnt;
    logic             ov_q;
    logic             un_q;

    // Derived combinational values.
    logic [PW-1:0]    sp_inc;
    logic [PW-1:0]    sp_dec;
    logic             is_empty;
    logic             is_full;
    op_e              op;

    // Next-state controls.
    logic [PW-1:0]    sp_next;
    logic [CW-1:0]    cnt_next;
    logic             wr_en;
    logic [PW-1:0]    wr_addr;
    logic             ov_set;
    logic             un_set;

    // Pointer neighbours with explicit modulo-DEPTH wrap; sp_dec is the top slot.
    always_comb begin
        sp_inc = (sp == SP_LAST) ? '0 : sp + 1'b1;
        sp_dec = (sp == '0) ? SP_LAST : sp - 1'b1;
    end

    // Occupancy status straight from the registered count.
    always_comb begin
        is_empty = (cnt == '0);
        is_full  = (cnt == CNT_MAX);
    end

    // Resolve the request priority: flush beats push/pop (rst is handled in the register).
    always_comb begin
        // NOTE: every signal written in a combinational block gets a default
        // first, so no path through the logic can leave it unassigned (latch).
        op = OP_HOLD;
        if (flush) begin
            op = OP_FLUSH;
        end else if (push && pop) begin
            op = is_empty ? OP_PUSH_POP_EMPTY : OP_REPLACE;
        end else if (push) begin
            op = is_full ? OP_PUSH_FULL : OP_PUSH;
        end else if (pop) begin
            op = is_empty ? OP_POP_EMPTY : OP_POP;
        end
    end

    // Translate the resolved operation into pointer, count, write and flag updates.
    always_comb begin
        sp_next  = sp;
        cnt_next = cnt;
        wr_en    = 1'b0;
        wr_addr  = sp;
        ov_set   = 1'b0;
        un_set   = 1'b0;

        unique case (op)
            OP_FLUSH: begin
                sp_next  = '0;
                cnt_next = '0;
            end
            OP_PUSH: begin
                wr_en    = 1'b1;
                sp_next  = sp_inc;
                cnt_next = cnt + 1'b1;
            end
            OP_PUSH_FULL: begin
                ov_set = 1'b1;
                // In ring mode the free slot is the oldest entry; count stays at DEPTH.
                if (WRAP_MODE != 0) begin
                    wr_en   = 1'b1;
                    sp_next = sp_inc;
                end
            end
            OP_POP: begin
                sp_next  = sp_dec;
                cnt_next = cnt - 1'b1;
            end
            OP_POP_EMPTY: begin
                un_set = 1'b1;
            end
            OP_REPLACE: begin
                // Tail call: the callee's return address replaces the caller's.
                wr_en   = 1'b1;
                wr_addr = sp_dec;
            end
            OP_PUSH_POP_EMPTY: begin
                wr_en    = 1'b1;
                sp_next  = sp_inc;
                cnt_next = cnt + 1'b1;
                un_set   = 1'b1;
            end
            default: begin
                // OP_HOLD keeps every default.
            end
        endcase
    end

    // Pointer, count and sticky flags; reset is synchronous and overrides all inputs.
    always_ff @(posedge clk) begin
        // NOTE: registered state is assigned with non-blocking (<=) so every
        // flop samples the pre-edge values regardless of statement order.
        if (rst) begin
            sp   <= '0;
            cnt  <= '0;
            ov_q <= 1'b0;
            un_q <= 1'b0;
        end else begin
            sp   <= sp_next;
            cnt  <= cnt_next;
            // A new error event wins over a same-cycle clear.
            ov_q <= (ov_q & ~err_clr) | ov_set;
            un_q <= (un_q & ~err_clr) | un_set;
        end
    end

    // Entry storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; validity is tracked by cnt, so
        // clearing it would only add reset fan-out and block RAM inference.
        // A write accepted alongside rst is harmless because cnt returns to 0.
        if (wr_en) begin
            mem[wr_addr] <= din;
        end
    end

    // Zero-latency outputs derived from registered state.
    always_comb begin
        top       = is_empty ? '0 : mem[sp_dec];
        count     = cnt;
        empty     = is_empty;
        full      = is_full;
        overflow  = ov_q;
        underflow = un_q;
    end

endmodule

// File: tb/tb_call_stack_param.sv
// tb_call_stack_param: scoreboard bench for call_stack_param.
//
// Three instances run side by side: DEPTH=4 reject, DEPTH=4 ring, DEPTH=3 ring.
// Each cycle the stimulus process drives inputs on the falling edge, advances a
// queue-based reference model per instance and pushes the expected outputs into
// a scoreboard queue. A separate monitor pops and compares just after each
// rising edge. Directed scenarios come first, then randomized traffic.

module tb_call_stack_param;

    localparam int W = 12;
    localparam int N = 3;

    typedef struct packed {
        logic         rst;
        logic         push;
        logic         pop;
        logic         flush;
        logic         err_clr;
        logic [W-1:0] din;
    } stim_t;

    typedef struct packed {
        logic [1:0]   idx;
        logic [W-1:0] top;
        logic [3:0]   count;
        logic         empty;
        logic         full;
        logic         ov;
        logic         un;
    } exp_t;

    logic clk = 1'b0;

    // Per-instance stimulus wires.
    logic         rst_s     [N];
    logic         push_s    [N];
    logic         pop_s     [N];
    logic         flush_s   [N];
    logic         err_clr_s [N];
    logic [W-1:0] din_s     [N];

    // Per-instance outputs.
    logic [W-1:0] top_o   [N];
    logic [2:0]   count0;
    logic [2:0]   count1;
    logic [1:0]   count2;
    logic         empty_o [N];
    logic         full_o  [N];
    logic         ov_o    [N];
    logic         un_o    [N];

    // Reference model: a plain queue per instance, newest entry at the back.
    logic [W-1:0] model [N][$];
    bit           m_ov  [N];
    bit           m_un  [N];
    int           depth_of [N];
    bit           wrap_of  [N];

    stim_t st [N];
    exp_t  exp_q [$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    call_stack_param #(.WIDTH(W), .DEPTH(4), .WRAP_MODE(0)) dut0 (
        .clk(clk), .rst(rst_s[0]), .push(push_s[0]), .pop(pop_s[0]),
        .flush(flush_s[0]), .err_clr(err_clr_s[0]), .din(din_s[0]),
        .top(top_o[0]), .count(count0), .empty(empty_o[0]), .full(full_o[0]),
        .overflow(ov_o[0]), .underflow(un_o[0])
    );

    call_stack_param #(.WIDTH(W), .DEPTH(4), .WRAP_MODE(1)) dut1 (
        .clk(clk), .rst(rst_s[1]), .push(push_s[1]), .pop(pop_s[1]),
        .flush(flush_s[1]), .err_clr(err_clr_s[1]), .din(din_s[1]),
        .top(top_o[1]), .count(count1), .empty(empty_o[1]), .full(full_o[1]),
        .overflow(ov_o[1]), .underflow(un_o[1])
    );

    call_stack_param #(.WIDTH(W), .DEPTH(3), .WRAP_MODE(1)) dut2 (
        .clk(clk), .rst(rst_s[2]), .push(push_s[2]), .pop(pop_s[2]),
        .flush(flush_s[2]), .err_clr(err_clr_s[2]), .din(din_s[2]),
        .top(top_o[2]), .count(count2), .empty(empty_o[2]), .full(full_o[2]),
        .overflow(ov_o[2]), .underflow(un_o[2])
    );

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d @%0t: got 0x%0h, expected 0x%0h", name, k, $time, act, exp);
        end
    endtask

    // Apply the stack rules for one cycle of instance k.
    task automatic model_step(input int k);
        stim_t s;
        s = st[k];
        if (s.rst) begin
            model[k].delete();
            m_ov[k] = 1'b0;
            m_un[k] = 1'b0;
        end else begin
            if (s.err_clr) begin
                m_ov[k] = 1'b0;
                m_un[k] = 1'b0;
            end
            if (s.flush) begin
                model[k].delete();
            end else if (s.push && s.pop) begin
                if (model[k].size() > 0) begin
                    model[k][model[k].size()-1] = s.din;
                end else begin
                    model[k].push_back(s.din);
                    m_un[k] = 1'b1;
                end
            end else if (s.push) begin
                if (model[k].size() < depth_of[k]) begin
                    model[k].push_back(s.din);
                end else begin
                    m_ov[k] = 1'b1;
                    if (wrap_of[k]) begin
                        void'(model[k].pop_front());
                        model[k].push_back(s.din);
                    end
                end
            end else if (s.pop) begin
                if (model[k].size() > 0) void'(model[k].pop_back());
                else m_un[k] = 1'b1;
            end
        end
    endtask

    // Drive one cycle of stimulus and queue the expected post-edge outputs.
    task automatic drive_cycle();
        exp_t e;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            rst_s[k]     = st[k].rst;
            push_s[k]    = st[k].push;
            pop_s[k]     = st[k].pop;
            flush_s[k]   = st[k].flush;
            err_clr_s[k] = st[k].err_clr;
            din_s[k]     = st[k].din;
            model_step(k);
            e.idx   = 2'(k);
            e.top   = (model[k].size() > 0) ? model[k][model[k].size()-1] : '0;
            e.count = 4'(model[k].size());
            e.empty = (model[k].size() == 0);
            e.full  = (model[k].size() == depth_of[k]);
            e.ov    = m_ov[k];
            e.un    = m_un[k];
            exp_q.push_back(e);
        end
    endtask

    // Same request to all three instances.
    task automatic op(input bit r, input bit ps, input bit pp, input bit fl, input bit ec, input logic [W-1:0] d);
        for (int k = 0; k < N; k++) begin
            st[k].rst     = r;
            st[k].push    = ps;
            st[k].pop     = pp;
            st[k].flush   = fl;
            st[k].err_clr = ec;
            st[k].din     = d;
        end
        drive_cycle();
    endtask

    task automatic do_rst();              op(1, 0, 0, 0, 0, '0); endtask
    task automatic do_push(input logic [W-1:0] d); op(0, 1, 0, 0, 0, d); endtask
    task automatic do_pop();              op(0, 0, 1, 0, 0, '0); endtask
    task automatic do_idle();             op(0, 0, 0, 0, 0, '0); endtask

    // Monitor: compare every queued expectation just after the rising edge.
    always begin
        exp_t e;
        logic [3:0] act_count;
        int k;
        @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            k = int'(e.idx);
            case (k)
                0:       act_count = {1'b0, count0};
                1:       act_count = {1'b0, count1};
                default: act_count = {2'b00, count2};
            endcase
            check("top",       k, 32'(top_o[k]),   32'(e.top));
            check("count",     k, 32'(act_count),  32'(e.count));
            check("empty",     k, 32'(empty_o[k]), 32'(e.empty));
            check("full",      k, 32'(full_o[k]),  32'(e.full));
            check("overflow",  k, 32'(ov_o[k]),    32'(e.ov));
            check("underflow", k, 32'(un_o[k]),    32'(e.un));
        end
    end

    // Hard time limit in case the clock or a process stalls.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        depth_of = '{4, 4, 3};
        wrap_of  = '{1'b0, 1'b1, 1'b1};
        for (int k = 0; k < N; k++) begin
            st[k]        = '0;
            rst_s[k]     = 1'b0;
            push_s[k]    = 1'b0;
            pop_s[k]     = 1'b0;
            flush_s[k]   = 1'b0;
            err_clr_s[k] = 1'b0;
            din_s[k]     = '0;
            m_ov[k]      = 1'b0;
            m_un[k]      = 1'b0;
        end

        // Reset and fill, overflow on full, drain in LIFO order.
        do_rst();
        for (int i = 1; i <= 4; i++) do_push(12'h100 + 12'(i));
        do_push(12'h105);
        for (int i = 0; i < 4; i++) do_pop();

        // Underflow, clear, and set-wins-over-clear.
        do_rst();
        do_pop();
        op(0, 0, 0, 0, 1, '0);
        op(0, 0, 1, 0, 1, '0);
        do_idle();

        // Ring behaviour: six pushes, then five pops.
        do_rst();
        for (int i = 1; i <= 6; i++) do_push(12'(i));
        for (int i = 0; i < 5; i++) do_pop();

        // Simultaneous push+pop with entries and on an empty stack.
        do_rst();
        do_push(12'h0A0);
        do_push(12'h0B0);
        op(0, 1, 1, 0, 0, 12'h0C0);
        do_pop();
        do_pop();
        op(0, 1, 1, 0, 0, 12'h033);

        // Replace while full is not an error.
        do_rst();
        for (int i = 0; i < 4; i++) do_push(12'h200 + 12'(i));
        op(0, 1, 1, 0, 0, 12'h2FF);

        // Flush beats push; flags untouched; err_clr still honoured with flush.
        do_rst();
        do_pop();
        for (int i = 0; i < 3; i++) do_push(12'h300 + 12'(i));
        op(0, 1, 0, 1, 0, 12'h7FF);
        do_push(12'h7FF);
        op(0, 0, 0, 1, 1, '0);

        // Reset mid-operation with overflow set; the concurrent push is ignored.
        do_rst();
        for (int i = 0; i < 5; i++) do_push(12'h400 + 12'(i));
        do_pop();
        do_pop();
        op(1, 1, 0, 0, 0, 12'h4AA);

        // Five pushes then pops: DEPTH=3 ring returns the last three, newest first.
        do_rst();
        for (int i = 1; i <= 5; i++) do_push(12'h500 + 12'(i));
        for (int i = 0; i < 4; i++) do_pop();

        // Randomized traffic, independent per instance.
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < N; k++) begin
                st[k].rst     = ($urandom_range(63) == 0);
                st[k].flush   = ($urandom_range(15) == 0);
                st[k].err_clr = ($urandom_range(7) == 0);
                st[k].push    = 1'($urandom_range(1));
                st[k].pop     = 1'($urandom_range(1));
                st[k].din     = W'($urandom);
            end
            drive_cycle();
        end
        do_idle();

        // Let the monitor drain the scoreboard, bounded.
        for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
